// File: rtl/mac_pkg.sv
// Shared widths, result payload and add/subtract encoding for the mac16 datapath.
package mac_pkg;

  localparam int unsigned OP_W   = 16;
  localparam int unsigned RES_W  = 32;
  localparam int unsigned HALF_W = RES_W / 2;
  localparam int unsigned LANE_W = OP_W / 2;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } addsub_e;

  // Output-register payload: 32-bit sum plus carry-out.
  typedef struct packed {
    logic             co;
    logic [RES_W-1:0] sum;
  } mac_res_t;

endpackage

// File: rtl/mac16_mult.sv
// Combinational 16x16 multiplier with per-operand signedness and a split
// mode producing two independent 8x8 lane products packed as {top, bottom}.
module mac16_mult
  import mac_pkg::*;
#(
  parameter bit A_SIGNED = 1'b1,
  parameter bit B_SIGNED = 1'b1,
  parameter bit MODE_8x8 = 1'b0
) (
  input  logic [OP_W-1:0]  a_i,
  input  logic [OP_W-1:0]  b_i,
  output logic [RES_W-1:0] prod_o
);

  logic [RES_W-1:0] a_ext, b_ext, p_full;
  logic [OP_W-1:0]  at_ext, bt_ext, ab_ext, bb_ext;
  logic [OP_W-1:0]  p_top, p_bot;

  always_comb begin
    a_ext  = A_SIGNED ? {{OP_W{a_i[OP_W-1]}}, a_i} : {{OP_W{1'b0}}, a_i};
    b_ext  = B_SIGNED ? {{OP_W{b_i[OP_W-1]}}, b_i} : {{OP_W{1'b0}}, b_i};
    // Low 32 bits of the extended product are exact for either signedness.
    p_full = a_ext * b_ext;

    at_ext = A_SIGNED ? {{LANE_W{a_i[OP_W-1]}}, a_i[OP_W-1 -: LANE_W]}
                      : {{LANE_W{1'b0}}, a_i[OP_W-1 -: LANE_W]};
    bt_ext = B_SIGNED ? {{LANE_W{b_i[OP_W-1]}}, b_i[OP_W-1 -: LANE_W]}
                      : {{LANE_W{1'b0}}, b_i[OP_W-1 -: LANE_W]};
    ab_ext = A_SIGNED ? {{LANE_W{a_i[LANE_W-1]}}, a_i[LANE_W-1:0]}
                      : {{LANE_W{1'b0}}, a_i[LANE_W-1:0]};
    bb_ext = B_SIGNED ? {{LANE_W{b_i[LANE_W-1]}}, b_i[LANE_W-1:0]}
                      : {{LANE_W{1'b0}}, b_i[LANE_W-1:0]};
    p_top  = at_ext * bt_ext;
    p_bot  = ab_ext * bb_ext;

    prod_o = MODE_8x8 ? {p_top, p_bot} : p_full;
  end

endmodule

// File: rtl/mac16_unit.sv
// 16x16 multiply-add/accumulate slice: optional input registers, multiplier,
// 33-bit add/subtract against {d,c} or the running output, registered result.
module mac16_unit
  import mac_pkg::*;
#(
  parameter bit A_SIGNED = 1'b1,
  parameter bit B_SIGNED = 1'b1,
  parameter bit MODE_8x8 = 1'b0,
  parameter bit A_REG    = 1'b0,
  parameter bit B_REG    = 1'b0,
  parameter bit C_REG    = 1'b0,
  parameter bit D_REG    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  input  logic [OP_W-1:0]  c,
  input  logic [OP_W-1:0]  d,
  input  logic             ahold,
  input  logic             bhold,
  input  logic             chold,
  input  logic             dhold,
  input  logic             addsub,
  input  logic             accum_en,
  input  logic             ohold,
  input  logic             ci,
  output logic [RES_W-1:0] o,
  output logic             co
);

  logic [OP_W-1:0]  a_q, b_q, c_q, d_q;
  logic [OP_W-1:0]  a_d, b_d, c_d, d_d;
  logic [OP_W-1:0]  a_s, b_s, c_s, d_s;
  logic [RES_W-1:0] prod;
  mac_res_t         res_q, res_d;

  logic [RES_W-1:0]  x_op, p_op;
  logic              is_sub, cin_lo;
  logic [RES_W:0]    sum_full;
  logic [HALF_W:0]   sum_top;
  logic [HALF_W-1:0] sum_bot;

  // Input staging; registers are bypassed when the matching *_REG is clear.
  always_comb begin
    a_d = (ce && !ahold) ? a : a_q;
    b_d = (ce && !bhold) ? b : b_q;
    c_d = (ce && !chold) ? c : c_q;
    d_d = (ce && !dhold) ? d : d_q;
    a_s = A_REG ? a_q : a;
    b_s = B_REG ? b_q : b;
    c_s = C_REG ? c_q : c;
    d_s = D_REG ? d_q : d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      d_q <= d_d;
    end
  end

  mac16_mult #(
    .A_SIGNED (A_SIGNED),
    .B_SIGNED (B_SIGNED),
    .MODE_8x8 (MODE_8x8)
  ) u_mult (
    .a_i    (a_s),
    .b_i    (b_s),
    .prod_o (prod)
  );

  // Subtraction is X + ~P + 1; carry-in only participates when adding.
  always_comb begin
    res_d    = res_q;
    is_sub   = (addsub_e'(addsub) == SUB);
    x_op     = accum_en ? res_q.sum : {d_s, c_s};
    p_op     = is_sub ? ~prod : prod;
    cin_lo   = is_sub ? 1'b1 : ci;
    sum_full = {1'b0, x_op} + {1'b0, p_op} + (RES_W+1)'(cin_lo);
    sum_top  = {1'b0, x_op[RES_W-1 -: HALF_W]} + {1'b0, p_op[RES_W-1 -: HALF_W]}
             + (HALF_W+1)'(is_sub);
    sum_bot  = x_op[HALF_W-1:0] + p_op[HALF_W-1:0] + HALF_W'(cin_lo);

    if (ce && !ohold) begin
      if (MODE_8x8) begin
        res_d.sum = {sum_top[HALF_W-1:0], sum_bot};
        res_d.co  = sum_top[HALF_W];
      end else begin
        res_d.sum = sum_full[RES_W-1:0];
        res_d.co  = sum_full[RES_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign o  = res_q.sum;
  assign co = res_q.co;

endmodule

// File: tb/tb_mac16_unit.sv
// Bench for mac16_unit: three configurations driven from shared inputs and
// checked against an arithmetic reference model plus directed vectors.
module tb_mac16_unit;

  logic        clk = 1'b0;
  logic        rst_n, ce, ahold, bhold, chold, dhold, addsub, accum_en, ohold, ci;
  logic [15:0] a, b, c, d;
  logic [31:0] o0, o1, o8;
  logic        co0, co1, co8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Signed 16x16, combinational inputs.
  mac16_unit #(.A_SIGNED(1'b1), .B_SIGNED(1'b1), .MODE_8x8(1'b0),
               .A_REG(1'b0), .B_REG(1'b0), .C_REG(1'b0), .D_REG(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .a(a), .b(b), .c(c), .d(d),
    .ahold(ahold), .bhold(bhold), .chold(chold), .dhold(dhold),
    .addsub(addsub), .accum_en(accum_en), .ohold(ohold), .ci(ci),
    .o(o0), .co(co0));

  // Unsigned a, signed b.
  mac16_unit #(.A_SIGNED(1'b0), .B_SIGNED(1'b1), .MODE_8x8(1'b0),
               .A_REG(1'b0), .B_REG(1'b0), .C_REG(1'b0), .D_REG(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .a(a), .b(b), .c(c), .d(d),
    .ahold(ahold), .bhold(bhold), .chold(chold), .dhold(dhold),
    .addsub(addsub), .accum_en(accum_en), .ohold(ohold), .ci(ci),
    .o(o1), .co(co1));

  // Dual 8x8 unsigned lanes, all inputs registered.
  mac16_unit #(.A_SIGNED(1'b0), .B_SIGNED(1'b0), .MODE_8x8(1'b1),
               .A_REG(1'b1), .B_REG(1'b1), .C_REG(1'b1), .D_REG(1'b1)) u8 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .a(a), .b(b), .c(c), .d(d),
    .ahold(ahold), .bhold(bhold), .chold(chold), .dhold(dhold),
    .addsub(addsub), .accum_en(accum_en), .ohold(ohold), .ci(ci),
    .o(o8), .co(co8));

  // Reference model state.
  logic [31:0] m0_o = '0, m1_o = '0, m8_o = '0;
  logic        m0_co = 1'b0, m1_co = 1'b0, m8_co = 1'b0;
  logic [15:0] ar = '0, br = '0, cr = '0, dr = '0;

  typedef struct {
    logic [15:0] va, vb, vc, vd;
    logic        vsub, vci;
    logic [31:0] e0;
    logic        eco;
    logic [31:0] eu;
  } vec_t;
  vec_t tv[8];

  function automatic logic [32:0] ref16(input logic [31:0] x, input logic [15:0] fa,
                                        input logic [15:0] fb, input bit asg, input bit bsg,
                                        input bit sub, input bit cin);
    longint pa, pb, p, r;
    pa = asg ? longint'($signed(fa)) : longint'(fa);
    pb = bsg ? longint'($signed(fb)) : longint'(fb);
    p  = (pa * pb) & 64'hFFFF_FFFF;
    if (sub) r = longint'(x) + 64'h1_0000_0000 - p;
    else     r = longint'(x) + p + longint'(cin);
    return r[32:0];
  endfunction

  function automatic logic [32:0] ref8(input logic [31:0] x, input logic [15:0] fa,
                                       input logic [15:0] fb, input bit sub, input bit cin);
    int unsigned ah, bh, al, bl, xh, xl, t, bt;
    ah = fa[15:8]; bh = fb[15:8]; al = fa[7:0]; bl = fb[7:0];
    xh = x[31:16]; xl = x[15:0];
    t  = sub ? (xh + 65536 - ah * bh) : (xh + ah * bh);
    bt = sub ? (xl + 65536 - al * bl) : (xl + al * bl + cin);
    return {t[16], t[15:0], bt[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: predict from pre-edge inputs/state, then compare after the edge.
  task automatic cycle();
    logic [32:0] r0, r1, r8;
    logic [31:0] n0o, n1o, n8o;
    logic        n0co, n1co, n8co;
    logic [15:0] nar, nbr, ncr, ndr;
    n0o = m0_o; n1o = m1_o; n8o = m8_o;
    n0co = m0_co; n1co = m1_co; n8co = m8_co;
    nar = ar; nbr = br; ncr = cr; ndr = dr;
    if (!rst_n) begin
      n0o = '0; n1o = '0; n8o = '0;
      n0co = 1'b0; n1co = 1'b0; n8co = 1'b0;
      nar = '0; nbr = '0; ncr = '0; ndr = '0;
    end else begin
      if (ce && !ohold) begin
        r0 = ref16(accum_en ? m0_o : {d, c}, a, b, 1'b1, 1'b1, addsub, ci);
        r1 = ref16(accum_en ? m1_o : {d, c}, a, b, 1'b0, 1'b1, addsub, ci);
        r8 = ref8(accum_en ? m8_o : {dr, cr}, ar, br, addsub, ci);
        n0o = r0[31:0]; n0co = r0[32];
        n1o = r1[31:0]; n1co = r1[32];
        n8o = r8[31:0]; n8co = r8[32];
      end
      if (ce && !ahold) nar = a;
      if (ce && !bhold) nbr = b;
      if (ce && !chold) ncr = c;
      if (ce && !dhold) ndr = d;
    end
    @(posedge clk);
    #1;
    m0_o = n0o; m1_o = n1o; m8_o = n8o;
    m0_co = n0co; m1_co = n1co; m8_co = n8co;
    ar = nar; br = nbr; cr = ncr; dr = ndr;
    chk("u0_o", o0, m0_o);   chk("u0_co", 32'(co0), 32'(m0_co));
    chk("u1_o", o1, m1_o);   chk("u1_co", 32'(co1), 32'(m1_co));
    chk("u8_o", o8, m8_o);   chk("u8_co", 32'(co8), 32'(m8_co));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tv[0] = '{16'h0005, 16'h0003, 16'd10,   16'h0000, 1'b0, 1'b0, 32'd25,        1'b0, 32'd25};
    tv[1] = '{16'hFFFE, 16'h0003, 16'h0000, 16'h0000, 1'b0, 1'b0, 32'hFFFFFFFA,  1'b0, 32'h0002FFFA};
    tv[2] = '{16'h0005, 16'h0003, 16'd100,  16'h0000, 1'b1, 1'b0, 32'd85,        1'b1, 32'd85};
    tv[3] = '{16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'h00000000,  1'b1, 32'h00000000};
    tv[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 32'h00000001,  1'b0, 32'h00000001};
    tv[5] = '{16'h0002, 16'h0002, 16'h0003, 16'h0000, 1'b1, 1'b1, 32'hFFFFFFFF,  1'b0, 32'hFFFFFFFF};
    tv[6] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0, 32'h00000001,  1'b0, 32'hFFFF0001};
    tv[7] = '{16'hFFFF, 16'h0002, 16'h0000, 16'h0000, 1'b0, 1'b0, 32'hFFFFFFFE,  1'b0, 32'h0001FFFE};

    rst_n = 1'b0; ce = 1'b1; ahold = 1'b0; bhold = 1'b0; chold = 1'b0; dhold = 1'b0;
    ohold = 1'b0; addsub = 1'b1; accum_en = 1'b1; ci = 1'b1;
    a = 16'h1234; b = 16'hBEEF; c = 16'h5A5A; d = 16'hC3C3;
    cycle();
    cycle();
    chk("reset_o0", o0, 32'd0);
    chk("reset_co0", 32'(co0), 32'd0);
    chk("reset_o8", o8, 32'd0);

    // First transaction and steady hold of the same inputs.
    rst_n = 1'b1; addsub = 1'b0; accum_en = 1'b0; ci = 1'b0;
    a = 16'd5; b = 16'd3; c = 16'd10; d = 16'd0;
    cycle();
    chk("first_result", o0, 32'd25);
    cycle();
    chk("result_stays", o0, 32'd25);

    for (int i = 0; i < 8; i++) begin
      a = tv[i].va; b = tv[i].vb; c = tv[i].vc; d = tv[i].vd;
      addsub = tv[i].vsub; ci = tv[i].vci;
      cycle();
      chk($sformatf("vec%0d_o", i), o0, tv[i].e0);
      chk($sformatf("vec%0d_co", i), 32'(co0), 32'(tv[i].eco));
      chk($sformatf("vec%0d_uns_o", i), o1, tv[i].eu);
    end

    // Accumulate from reset, then holds and a mid-run reset.
    rst_n = 1'b0; cycle();
    rst_n = 1'b1; accum_en = 1'b1; addsub = 1'b0; ci = 1'b0;
    a = 16'd2; b = 16'd3; c = 16'h7777; d = 16'h1111;
    for (int k = 1; k <= 3; k++) begin
      cycle();
      chk($sformatf("accum_%0d", k), o0, 32'(6 * k));
    end
    ohold = 1'b1; cycle(); chk("ohold_freeze", o0, 32'd18);
    ohold = 1'b0; ce = 1'b0; cycle(); chk("ce_freeze", o0, 32'd18);
    ce = 1'b1; rst_n = 1'b0; cycle(); chk("mid_reset", o0, 32'd0);
    rst_n = 1'b1;

    // Dual 8x8 with registered inputs: two-cycle latency, ahold freezes a.
    rst_n = 1'b0; cycle();
    rst_n = 1'b1; accum_en = 1'b0; addsub = 1'b0; ci = 1'b0;
    a = 16'h0304; b = 16'h0506; c = 16'h0001; d = 16'h0002;
    cycle(); chk("m8_latency1", o8, 32'd0);
    cycle(); chk("m8_result", o8, 32'h00110019);
    ahold = 1'b1; a = 16'h0909;
    cycle(); cycle(); chk("m8_ahold", o8, 32'h00110019);
    ahold = 1'b0;

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
      addsub   = 1'($urandom_range(0, 1));
      accum_en = 1'($urandom_range(0, 1));
      ci       = 1'($urandom_range(0, 1));
      ce       = ($urandom_range(0, 7) != 0);
      ahold    = ($urandom_range(0, 3) == 0);
      bhold    = ($urandom_range(0, 3) == 0);
      chold    = ($urandom_range(0, 3) == 0);
      dhold    = ($urandom_range(0, 3) == 0);
      ohold    = ($urandom_range(0, 7) == 0);
      rst_n    = ($urandom_range(0, 31) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac16_unit.md
Name: mac16_unit

Overview:
- Single-clock 16x16 multiply-add/accumulate block, modelled on the FPGA hard DSP slice.
- Computes a*b with selectable operand signedness, then adds or subtracts a 32-bit addend {d,c}, or accumulates into its own output register.
- An 8x8 dual mode splits the datapath into two independent 16-bit lanes.
- Used as the arithmetic core for filter and MAC datapaths.

Parameters:
- A_SIGNED, 1, operand a treated as two's complement (0 = unsigned).
- B_SIGNED, 1, operand b treated as two's complement.
- MODE_8x8, 0, 1 = two independent 8x8 lanes; 0 = one 16x16 multiply.
- A_REG, 0, 1 = register a at the input; 0 = combinational pass-through.
- B_REG, 0, same for b.
- C_REG, 0, same for c.
- D_REG, 0, same for d.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- ce  in  1  clock enable for every register in the block.
- a  in  16  multiplicand.
- b  in  16  multiplier.
- c  in  16  addend, low half.
- d  in  16  addend, high half.
- ahold, bhold, chold, dhold  in  1 each  hold the matching input register (no effect when that *_REG = 0).
- addsub  in  1  0 = add, 1 = subtract the product.
- accum_en  in  1  1 = accumulate into o; 0 = use the {d,c} addend.
- ohold  in  1  hold the output register.
- ci  in  1  carry-in; used only when addsub = 0.
- o  out  32  registered result.
- co  out  1  registered carry-out of the 32-bit add.

Behaviour:
- Reset: at a clk edge with rst_n = 0, all input registers, o and co clear to 0. Reset overrides ce and all holds, including mid-accumulation.
- Input stage: with *_REG = 1, the register loads when ce = 1 and hold = 0. With *_REG = 0 the input feeds the datapath directly.
- 16x16 multiply (MODE_8x8 = 0):
  - P = ext(a) * ext(b), truncated to 32 bits.
  - ext is a sign extension when the matching *_SIGNED = 1, zero extension otherwise.
- Operand X selection:
  - X = o when accum_en = 1.
  - X = {d,c} otherwise; d is the high half, and the addend is never sign-extended.
- Result R, computed with 33-bit arithmetic:
  - addsub = 0: R = X + P + ci.
  - addsub = 1: R = X + ~P + 1.
  - Next o = R[31:0]; next co = R[32]. Results wrap modulo 2^32.
- 8x8 mode (MODE_8x8 = 1):
  - Top lane: Pt = a[15:8]*b[15:8]; Xt = o[31:16] if accum_en, else d.
  - Bottom lane: Pb = a[7:0]*b[7:0]; Xb = o[15:0] if accum_en, else c.
  - Each lane adds or subtracts per addsub and is 16-bit wrap.
  - ci feeds the bottom lane only. co = carry out of the top lane; the bottom-lane carry is discarded.
- Output register:
  - Updates when ce = 1 and ohold = 0.
  - ce = 0 or ohold = 1 freezes both o and co.
- Latency, inputs to o:
  - 1 cycle when the relevant *_REG = 0.
  - 2 cycles when registered.
- No X/Z may propagate from uninitialised state. All registers are defined after the first reset edge.

Decomposition:
- Shared package mac_pkg: operand width constant (16), result width constant (32), and an addsub encoding enum (ADD = 0, SUB = 1).
- One natural sub-module: mac16_mult, a combinational signed/unsigned 16x16 multiplier with a split 8x8 mode.
- Input registers, the adder and the output register stay in the top level.

Test Plan:
- Hold rst_n = 0 for 2 cycles with arbitrary inputs -> o = 0, co = 0. Release it, then apply a = 5, b = 3, c = 10, d = 0, addsub = 0, accum_en = 0, ce = 1 -> o = 25 one cycle later and it stays 25.
- Signed operands: a = 0xFFFE (-2), b = 3, c = d = 0 -> o = 0xFFFFFFFA. With A_SIGNED = 0, a = 0xFFFF, b = 2 -> o = 0x0001FFFE.
- Subtract: addsub = 1, c = 100, a = 5, b = 3 -> o = 85, co = 1.
- Carry and ci: a = 1, b = 1, {d,c} = 0xFFFFFFFF -> o = 0, co = 1. Then a = 0, b = 0, c = 0, d = 0, ci = 1 -> o = 1, co = 0.
- Accumulate and holds:
  - accum_en = 1, a = 2, b = 3 for 3 cycles from reset -> o = 6, 12, 18.
  - Asserting ohold or ce = 0 for one cycle -> o stays 18.
  - Asserting rst_n = 0 mid-run -> o = 0 on the next edge.
- MODE_8x8 = 1 with A_REG = B_REG = 1:
  - a = 0x0304, b = 0x0506, c = 1, d = 2 -> o = 0x00110019, two cycles after the inputs are applied.
  - Setting ahold = 1 and changing a -> the result is unchanged.
